mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1 (all state on rising edge); rst in 1 (asynchronous, active-high).
REQ-002 Pipeline-side ports SHALL be:
- memenM in 1: memory instruction valid in M.
- memopM in 3: op code.
- aluoutM in 32: effective address.
- writedataM in 32: store data.
- holdM in 1: M held by another stall source.
- flushM in 1: M instruction squashed.
- readdataM out 32: extended load data.
- stallM out 1: hold pipeline.
- adelM out 1: load address error.
- adesM out 1: store address error.
- badvaddrM out 32: faulting address.
REQ-003 Bus-side ports SHALL be:
- data_req out 1; data_wr out 1; data_size out 2 (0 byte, 1 half, 2 word); data_addr out 32; data_wdata out 32; data_wstrb out 4.
- data_addr_ok in 1; data_data_ok in 1; data_rdata in 32.

Function
REQ-004 memopM encoding SHALL be: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-005 Address-error detection SHALL be combinational:
- Halfword ops with aluoutM[0]=1 are misaligned.
- Word ops with aluoutM[1:0]!=0 are misaligned.
- Misaligned loads assert adelM; misaligned stores assert adesM.
- badvaddrM=aluoutM whenever either error is asserted; otherwise 0.
- A faulting access issues no bus request and does not assert stallM.
REQ-006 The FSM SHALL have states IDLE, REQ, WAIT, DONE and DRAIN.
REQ-007 IDLE: when memenM=1, flushM=0 and no error, assert data_req in the same cycle.
- data_addr_ok=1 -> go to WAIT.
- Otherwise -> go to REQ.
REQ-008 REQ: hold data_req=1 with stable bus outputs.
- data_addr_ok=1 -> WAIT.
- flushM=1 while data_addr_ok=0 -> drop data_req and return to IDLE.
REQ-009 WAIT: on data_data_ok=1, capture the extended load result into the hold register.
- holdM=1 -> go to DONE.
- holdM=0 -> go to IDLE.
- flushM=1 while data_data_ok=0 -> go to DRAIN.
REQ-010 DONE: readdataM is driven from the hold register; leave for IDLE when holdM=0. No new request is issued from DONE.
REQ-011 DRAIN: data_req=0; wait for data_data_ok, discard the data, then go to IDLE.
REQ-012 stallM SHALL be 1 in the following cases and 0 otherwise:
- IDLE with a request issued;
- REQ;
- WAIT with data_data_ok=0;
- DRAIN.
REQ-013 readdataM SHALL be the extended data_rdata in the WAIT cycle where data_data_ok=1, the hold register in DONE, and 0 otherwise.
REQ-014 Load extraction SHALL be little-endian:
- Byte lane = aluoutM[1:0]; halfword lane = aluoutM[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-015 Store formatting SHALL be:
- SB: data_wdata = byte replicated x4; data_wstrb = 0001 << aluoutM[1:0].
- SH: data_wdata = halfword replicated x2; data_wstrb = 0011 or 1100 selected by aluoutM[1].
- SW: data_wstrb = 1111.
- Loads: data_wstrb = 0000.
REQ-016 data_addr SHALL equal aluoutM unmodified. data_size SHALL be 0/1/2 for byte/half/word. data_wr SHALL be 1 for stores.
REQ-017 While data_req=1, all data_* outputs SHALL remain stable until data_addr_ok.
REQ-018 Exactly one bus transaction SHALL be issued per memory instruction, regardless of how long holdM persists.

Reset
REQ-019 On rst=1 the block SHALL asynchronously enter IDLE and clear the hold register.
REQ-020 All outputs SHALL be 0 during and immediately after reset.
REQ-021 Any outstanding bus response SHALL be abandoned; the bus slave is reset by the same rst.

Structure
REQ-022 The memopM encodings and FSM state encodings SHALL live in the shared definitions package used by the datapath and the controller.
REQ-023 Load extraction and sign/zero extension SHALL be one combinational sub-module, mem_load_ext (inputs: op, address[1:0], rdata; output: 32-bit result). Store formatting remains inline.

Verification
REQ-024 LB at address 0x00000013 with data_rdata=0x80FF7F01, addr_ok and data_ok both in the first cycle -> readdataM=0xFFFFFF80, stallM=0 in that cycle, data_size=0.
REQ-025 SH at address 0x00000006 with writedataM=0x1234ABCD -> data_wdata=0xABCDABCD, data_wstrb=1100, data_wr=1.
REQ-026 LW at address 0x00000102 -> adelM=1, badvaddrM=0x00000102, data_req=0, stallM=0.
REQ-027 LHU at 0x00000000 with addr_ok delayed 2 cycles and data_ok delayed 3 more, data_rdata=0x0000F00D:
- stallM=1 for 5 cycles, then 0 with readdataM=0x0000F00D;
- data_req rises exactly once.
REQ-028 LW where data_ok arrives while holdM=1 for 3 cycles -> DONE holds readdataM stable across those cycles, and no second data_req is issued.
REQ-029 Mid-access cases:
- flushM asserted in WAIT -> DRAIN, stallM=1 until data_ok, result discarded, IDLE next.
- rst asserted in REQ -> data_req=0 immediately (asynchronous).

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: op codes, FSM states, access sizes.
// The datapath, the load extractor and the controller all decode memopM from here.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } memop_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the memory access unit (master) and the memory slave.
// Request phase closes on data_addr_ok; response phase closes on data_data_ok.
interface mem_access_unit_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_load_ext.sv
// Little-endian lane extraction with sign/zero extension of load data.
// Purely combinational; store op codes produce zero.
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    result    = '0;
    case (op)
      OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  result = {24'd0, byte_lane};
      OP_LH:   result = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  result = {16'd0, half_lane};
      OP_LW:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: one bus transaction per instruction, stallM holds the pipe until data returns.
// Zero-latency when addr_ok and data_ok arrive with the request; result parked in a hold register while holdM.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic [2:0]        memopM,
  input  logic [31:0]       aluoutM,
  input  logic [31:0]       writedataM,
  input  logic              holdM,
  input  logic              flushM,
  output logic [31:0]       readdataM,
  output logic              stallM,
  output logic              adelM,
  output logic              adesM,
  output logic [31:0]       badvaddrM,
  mem_access_unit_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] hold_q;
  logic [31:0] ext_data;
  logic [31:0] rd_data;
  logic [1:0]  size;
  logic        is_store;
  logic        misaligned;
  logic        addr_err;
  logic        start;
  logic        req;
  logic        stall;
  logic        capture;
  logic        issue;

  assign size       = op_size(memopM);
  assign is_store   = op_is_store(memopM);
  assign misaligned = ((size == SIZE_HALF) && aluoutM[0]) ||
                      ((size == SIZE_WORD) && (aluoutM[1:0] != 2'b00));
  assign addr_err   = memenM && misaligned && !rst;
  assign start      = memenM && !flushM && !misaligned;

  assign adelM      = addr_err && !is_store;
  assign adesM      = addr_err && is_store;
  assign badvaddrM  = addr_err ? aluoutM : '0;

  mem_load_ext u_load_ext (
    .op     (memopM),
    .addr   (aluoutM[1:0]),
    .rdata  (bus.data_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_q <= ext_data;
      end
    end
  end

  // Data may return in the same cycle the address is accepted; that cycle completes without a stall.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    capture = 1'b0;
    rd_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = ST_REQ;
          if (bus.data_addr_ok) begin
            if (bus.data_data_ok) begin
              stall   = 1'b0;
              rd_data = ext_data;
              capture = 1'b1;
              state_d = holdM ? ST_DONE : ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            stall   = 1'b0;
            rd_data = ext_data;
            capture = 1'b1;
            state_d = holdM ? ST_DONE : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (flushM) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.data_data_ok) begin
          rd_data = ext_data;
          capture = 1'b1;
          state_d = holdM ? ST_DONE : ST_IDLE;
        end else begin
          stall = 1'b1;
          if (flushM) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DONE: begin
        rd_data = hold_q;
        if (!holdM) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (bus.data_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue     = req && !rst;
  assign stallM    = stall && !rst;
  assign readdataM = rst ? '0 : rd_data;

  assign bus.data_req  = issue;
  assign bus.data_wr   = issue && is_store;
  assign bus.data_size = issue ? size : 2'd0;
  assign bus.data_addr = issue ? aluoutM : '0;

  always_comb begin
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = '0;
    if (issue) begin
      case (memopM)
        OP_SB: begin
          bus.data_wstrb = 4'b0001 << aluoutM[1:0];
          bus.data_wdata = {4{writedataM[7:0]}};
        end
        OP_SH: begin
          bus.data_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
          bus.data_wdata = {2{writedataM[15:0]}};
        end
        OP_SW: begin
          bus.data_wstrb = 4'b1111;
          bus.data_wdata = writedataM;
        end
        default: begin
          bus.data_wstrb = 4'b0000;
          bus.data_wdata = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level reference model.
// The bench plays the bus slave with per-access address/data delays.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic [2:0]  memopM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        holdM;
  logic        flushM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        adelM;
  logic        adesM;
  logic [31:0] badvaddrM;

  int n_checks = 0;
  int n_errors = 0;
  int rises = 0;
  int handshakes = 0;
  int exp_handshakes = 0;
  logic req_prev = 1'b0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memopM     (memopM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .holdM      (holdM),
    .flushM     (flushM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .adelM      (adelM),
    .adesM      (adesM),
    .badvaddrM  (badvaddrM),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_prev <= bus.data_req;
    if (bus.data_req && !req_prev) rises <= rises + 1;
    if (bus.data_req && bus.data_addr_ok) handshakes <= handshakes + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 0;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 1;
    return 2;
  endfunction

  function automatic bit m_store(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic bit m_misal(input logic [2:0] op, input logic [31:0] addr);
    return (m_size(op) == 1 && addr % 2 != 0) || (m_size(op) == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * (addr % 4))) & 32'hFF;
    h = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd0:    return (b ^ 32'h80) - 32'h80;
      3'd1:    return b;
      3'd2:    return (h ^ 32'h8000) - 32'h8000;
      3'd3:    return h;
      3'd4:    return rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [2:0] op, input logic [31:0] addr);
    case (op)
      3'd5:    return 32'(1 << (addr % 4));
      3'd6:    return 32'(3 << (2 * ((addr / 2) % 2)));
      3'd7:    return 32'd15;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      3'd5:    return (wd & 32'hFF) * 32'h01010101;
      3'd6:    return (wd & 32'hFFFF) * 32'h00010001;
      3'd7:    return wd;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int da, input int dd, input int hold_extra);
    int r0;
    r0 = rises;
    memenM = 1'b1; memopM = op; aluoutM = addr; writedataM = wd;
    holdM = (hold_extra > 0); flushM = 1'b0; bus.data_rdata = rd;
    if (m_misal(op, addr)) begin
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      @(negedge clk);
      check({tag, "/adel"}, 32'(adelM), 32'(!m_store(op)));
      check({tag, "/ades"}, 32'(adesM), 32'(m_store(op)));
      check({tag, "/badv"}, badvaddrM, addr);
      check({tag, "/err_req"}, 32'(bus.data_req), 32'd0);
      check({tag, "/err_stall"}, 32'(stallM), 32'd0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c <= da + dd; c++) begin
        bus.data_addr_ok = (c == da);
        bus.data_data_ok = (c == da + dd);
        @(negedge clk);
        check({tag, "/req"}, 32'(bus.data_req), 32'(c <= da));
        check({tag, "/stall"}, 32'(stallM), 32'(c < da + dd));
        if (c == 0) begin
          check({tag, "/adel0"}, 32'(adelM | adesM), 32'd0);
          check({tag, "/badv0"}, badvaddrM, 32'd0);
        end
        if (c <= da) begin
          check({tag, "/addr"}, bus.data_addr, addr);
          check({tag, "/size"}, 32'(bus.data_size), 32'(m_size(op)));
          check({tag, "/wr"}, 32'(bus.data_wr), 32'(m_store(op)));
          check({tag, "/wstrb"}, 32'(bus.data_wstrb), m_wstrb(op, addr));
          if (m_store(op)) check({tag, "/wdata"}, bus.data_wdata, m_wdata(op, wd));
        end
        if (c < da + dd) check({tag, "/rd_busy"}, readdataM, 32'd0);
        else if (!m_store(op)) check({tag, "/rdata"}, readdataM, m_load(op, addr, rd));
        @(posedge clk); #1;
      end
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      bus.data_rdata = $urandom;
      exp_handshakes++;
      for (int k = 1; k <= hold_extra; k++) begin
        holdM = (k < hold_extra);
        @(negedge clk);
        if (!m_store(op)) check({tag, "/hold_rd"}, readdataM, m_load(op, addr, rd));
        check({tag, "/hold_stall"}, 32'(stallM), 32'd0);
        check({tag, "/hold_req"}, 32'(bus.data_req), 32'd0);
        @(posedge clk); #1;
      end
    end
    memenM = 1'b0; holdM = 1'b0;
    @(negedge clk);
    check({tag, "/idle_stall"}, 32'(stallM), 32'd0);
    check({tag, "/idle_req"}, 32'(bus.data_req), 32'd0);
    check({tag, "/rises"}, 32'(rises - r0), 32'(m_misal(op, addr) ? 0 : 1));
    @(posedge clk); #1;
  endtask

  task automatic flush_in_wait(input int da, input int dd);
    memenM = 1'b1; memopM = 3'd4; aluoutM = 32'h0000_0200; holdM = 1'b0; flushM = 1'b0;
    bus.data_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= da; c++) begin
      bus.data_addr_ok = (c == da); bus.data_data_ok = 1'b0;
      @(negedge clk);
      check("fw/req", 32'(bus.data_req), 32'd1);
      @(posedge clk); #1;
    end
    bus.data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    check("fw/flush_stall", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    flushM = 1'b0; memenM = 1'b0;
    for (int c = da + 2; c <= da + dd; c++) begin
      bus.data_data_ok = (c == da + dd);
      @(negedge clk);
      check("fw/drain_stall", 32'(stallM), 32'd1);
      check("fw/drain_req", 32'(bus.data_req), 32'd0);
      check("fw/drain_rd", readdataM, 32'd0);
      @(posedge clk); #1;
    end
    bus.data_data_ok = 1'b0;
    exp_handshakes++;
    @(negedge clk);
    check("fw/idle_stall", 32'(stallM), 32'd0);
    check("fw/idle_rd", readdataM, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    memenM = 1'b1; memopM = 3'd4; aluoutM = 32'h0000_0101; writedataM = 32'h0;
    holdM = 1'b0; flushM = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    @(negedge clk);
    check("rst/req", 32'(bus.data_req), 32'd0);
    check("rst/stall", 32'(stallM), 32'd0);
    check("rst/adel", 32'(adelM), 32'd0);
    check("rst/badv", badvaddrM, 32'd0);
    check("rst/rd", readdataM, 32'd0);
    memenM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst/req", 32'(bus.data_req), 32'd0);
    check("post_rst/stall", 32'(stallM), 32'd0);
    check("post_rst/rd", readdataM, 32'd0);
    check("post_rst/wstrb", 32'(bus.data_wstrb), 32'd0);
    @(posedge clk); #1;

    do_op("lb_same_cycle", 3'd0, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    do_op("sh_fmt", 3'd6, 32'h0000_0006, 32'h1234_ABCD, 32'h0, 1, 1, 0);
    do_op("lw_adel", 3'd4, 32'h0000_0102, 32'h0, 32'h0, 0, 0, 0);
    do_op("lhu_slow", 3'd3, 32'h0000_0000, 32'h0, 32'h0000_F00D, 2, 3, 0);
    do_op("lw_hold", 3'd4, 32'h0000_0040, 32'h0, 32'hCAFE_1234, 1, 2, 3);
    do_op("sw_ades", 3'd7, 32'h0000_0042, 32'h0, 32'h0, 0, 0, 0);

    flush_in_wait(1, 3);
    flush_in_wait(0, 2);

    // flush while the address phase is still pending
    memenM = 1'b1; memopM = 3'd1; aluoutM = 32'h0000_0031;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(posedge clk); #1;
    flushM = 1'b1;
    @(negedge clk);
    check("fr/req", 32'(bus.data_req), 32'd1);
    @(posedge clk); #1;
    flushM = 1'b0; memenM = 1'b0;
    @(negedge clk);
    check("fr/req_drop", 32'(bus.data_req), 32'd0);
    check("fr/stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;

    // asynchronous reset while in REQ
    memenM = 1'b1; memopM = 3'd4; aluoutM = 32'h0000_0080;
    @(posedge clk); #1;
    @(negedge clk);
    check("rr/req_before", 32'(bus.data_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr/req_async", 32'(bus.data_req), 32'd0);
    check("rr/stall_async", 32'(stallM), 32'd0);
    memenM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rr/req_after", 32'(bus.data_req), 32'd0);
    check("rr/stall_after", 32'(stallM), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op("rand", op, $urandom & 32'h0000_0FFF, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    check("handshakes", 32'(handshakes), 32'(exp_handshakes));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
